// File: rtl/cdf_lut_gen_if.sv
// Scratch-memory and control bundle between the controller/scratch memory and cdf_lut_gen.
// The slave side is the LUT generator; the master side is the scratch memory and controller.
interface cdf_lut_gen_if;
  logic         lut_start_in;
  logic [127:0] scratchmem_input;
  logic [15:0]  ReadAddress;
  logic         WE;
  logic [15:0]  WriteAddress;
  logic [127:0] WriteBus;
  logic         lut_busy;
  logic         lut_done;

  modport master (
    output lut_start_in, scratchmem_input,
    input  ReadAddress, WE, WriteAddress, WriteBus, lut_busy, lut_done
  );

  modport slave (
    input  lut_start_in, scratchmem_input,
    output ReadAddress, WE, WriteAddress, WriteBus, lut_busy, lut_done
  );
endinterface

// File: rtl/cdf_lut_gen.sv
// Scans the 256-bin CDF for cdf_min and total, then builds the 8-bit equalization LUT
// bin by bin (restoring divide) and writes it back packed 16 entries per 128-bit word.
module cdf_lut_gen #(
  parameter logic [15:0] CDF_BASE_ADDR = 16'd64,
  parameter logic [15:0] LUT_BASE_ADDR = 16'd128,
  parameter int          MAX_LEVEL     = 255
) (
  input  logic          clk,
  input  logic          reset,
  cdf_lut_gen_if.slave  bus
);

  localparam logic [31:0] MAX_Q = 32'(MAX_LEVEL);

  typedef enum logic [3:0] {
    IDLE, SCAN_RD, SCAN_CHK, MAP_RD, MAP_LD, DIV, PACK, WRITE, DONE
  } state_t;

  state_t         state, state_nxt;
  logic [5:0]     word;
  logic [7:0]     bin;
  logic [31:0]    cdf_min, total;
  logic [31:0]    quo, den_q;
  logic [32:0]    rem;
  logic [4:0]     div_cnt;
  logic [7:0]     lut;
  logic [127:0]   pack;

  logic [31:0]    lane0, lane1, lane2, lane3, sel, scan_val, den, num;
  logic           scan_hit, div_ge;
  logic [32:0]    rem_sh, rem_nxt;
  logic [31:0]    quo_nxt;
  logic [7:0]     quo_sat;
  logic [3:0]     pack_lane;

  assign lane0 = bus.scratchmem_input[127:96];
  assign lane1 = bus.scratchmem_input[95:64];
  assign lane2 = bus.scratchmem_input[63:32];
  assign lane3 = bus.scratchmem_input[31:0];

  // Lowest lane wins so cdf_min follows ascending bin order.
  assign scan_hit = (lane0 != '0) || (lane1 != '0) || (lane2 != '0) || (lane3 != '0);
  assign scan_val = (lane0 != '0) ? lane0 :
                    (lane1 != '0) ? lane1 :
                    (lane2 != '0) ? lane2 : lane3;

  always_comb begin
    sel = lane0;
    case (bin[1:0])
      2'd0: sel = lane0;
      2'd1: sel = lane1;
      2'd2: sel = lane2;
      default: sel = lane3;
    endcase
  end

  assign den = total - cdf_min;
  assign num = (sel - cdf_min) * MAX_Q;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh  = {rem[31:0], quo[31]};
  assign div_ge  = rem_sh >= {1'b0, den_q};
  assign rem_nxt = div_ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
  assign quo_nxt = {quo[30:0], div_ge};
  assign quo_sat = (quo_nxt > MAX_Q) ? MAX_Q[7:0] : quo_nxt[7:0];

  assign pack_lane = 4'd15 - bin[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.WE           = 1'b0;
    bus.lut_done     = 1'b0;
    bus.lut_busy     = 1'b1;
    bus.ReadAddress  = CDF_BASE_ADDR + {10'd0, word};
    bus.WriteAddress = LUT_BASE_ADDR + {12'd0, bin[7:4]};
    bus.WriteBus     = pack;
    case (state)
      IDLE: begin
        bus.lut_busy = 1'b0;
        if (bus.lut_start_in) state_nxt = SCAN_RD;
      end
      SCAN_RD:  state_nxt = SCAN_CHK;
      SCAN_CHK: state_nxt = (word == 6'd63) ? MAP_RD : SCAN_RD;
      MAP_RD: begin
        bus.ReadAddress = CDF_BASE_ADDR + {10'd0, bin[7:2]};
        state_nxt       = MAP_LD;
      end
      MAP_LD: begin
        bus.ReadAddress = CDF_BASE_ADDR + {10'd0, bin[7:2]};
        state_nxt       = (den == '0 || sel < cdf_min) ? PACK : DIV;
      end
      DIV:   if (div_cnt == 5'd31) state_nxt = PACK;
      PACK:  state_nxt = (bin[3:0] == 4'd15) ? WRITE : MAP_RD;
      WRITE: begin
        bus.WE    = 1'b1;
        state_nxt = (bin == 8'd255) ? DONE : MAP_RD;
      end
      DONE: begin
        bus.lut_busy = 1'b0;
        bus.lut_done = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word    <= '0;
      bin     <= '0;
      cdf_min <= '0;
      total   <= '0;
      quo     <= '0;
      den_q   <= '0;
      rem     <= '0;
      div_cnt <= '0;
      lut     <= '0;
      pack    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.lut_start_in) begin
          word    <= '0;
          bin     <= '0;
          cdf_min <= '0;
          total   <= '0;
          quo     <= '0;
          den_q   <= '0;
          rem     <= '0;
          div_cnt <= '0;
          lut     <= '0;
          pack    <= '0;
        end
        SCAN_CHK: begin
          // Latched values are nonzero, so zero doubles as "not yet found".
          if (cdf_min == '0 && scan_hit) cdf_min <= scan_val;
          if (word == 6'd63) begin
            total <= lane3;
            word  <= '0;
            bin   <= '0;
          end else begin
            word <= word + 6'd1;
          end
        end
        MAP_LD: begin
          if (den == '0) begin
            lut <= bin;
          end else if (sel < cdf_min) begin
            lut <= '0;
          end else begin
            quo     <= num;
            den_q   <= den;
            rem     <= '0;
            div_cnt <= '0;
          end
        end
        DIV: begin
          rem     <= rem_nxt;
          quo     <= quo_nxt;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) lut <= quo_sat;
        end
        PACK: begin
          pack[{pack_lane, 3'b000} +: 8] <= lut;
          if (bin[3:0] != 4'd15) bin <= bin + 8'd1;
        end
        WRITE: if (bin != 8'd255) bin <= bin + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_lut_gen.sv
// Randomized and directed histograms; a reference model queues the expected LUT writes
// and a negedge monitor compares every WE pulse against that queue.
module tb_cdf_lut_gen;
  logic clk;
  logic reset;
  cdf_lut_gen_if bus ();

  cdf_lut_gen dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t          exp_q[$];
  logic [127:0] mem [0:255];
  logic [127:0] rdata;
  int unsigned  hist [256];
  int           checks, passes, write_cnt, done_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[bus.ReadAddress[7:0]];
  assign bus.scratchmem_input = rdata;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passes++;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.WE) begin
      write_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 128'(bus.WriteAddress), 128'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 128'(bus.WriteAddress), 128'(e.addr));
        chk("write_data", bus.WriteBus, e.data);
      end
    end
    if (!reset && bus.lut_done) done_cnt++;
  end

  // Reference: cumulative sums, first nonzero CDF, then the equalization formula.
  task automatic build_expected();
    longint unsigned cdf [256];
    longint unsigned run, cmin, tot, d, v;
    logic [7:0]      lut [256];
    logic [127:0]    w;
    wr_t             e;
    run = 0;
    cmin = 0;
    for (int i = 0; i < 256; i++) begin
      run += hist[i];
      cdf[i] = run;
      if (cmin == 0 && run != 0) cmin = run;
    end
    tot = cdf[255];
    d = tot - cmin;
    for (int i = 0; i < 256; i++) begin
      if (d == 0)            lut[i] = 8'(i);
      else if (cdf[i] < cmin) lut[i] = 8'd0;
      else begin
        v = ((cdf[i] - cmin) * 255) / d;
        lut[i] = (v > 255) ? 8'd255 : 8'(v);
      end
    end
    for (int k = 0; k < 64; k++)
      mem[64 + k] = {32'(cdf[4*k]), 32'(cdf[4*k+1]), 32'(cdf[4*k+2]), 32'(cdf[4*k+3])};
    exp_q.delete();
    for (int j = 0; j < 16; j++) begin
      w = '0;
      for (int k = 0; k < 16; k++) w[(15 - k)*8 +: 8] = lut[16*j + k];
      e.addr = 16'(128 + j);
      e.data = w;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 256; i++) hist[i] = 0;
  endtask

  task automatic run(input string tag, input bit spurious);
    int cyc;
    build_expected();
    write_cnt = 0;
    done_cnt = 0;
    @(negedge clk) bus.lut_start_in = 1'b1;
    @(negedge clk) bus.lut_start_in = 1'b0;
    chk({tag, "_busy_after_start"}, 128'(bus.lut_busy), 128'd1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 9500) begin
      @(negedge clk);
      bus.lut_start_in = spurious && (cyc == 300 || cyc == 4000);
      cyc++;
    end
    bus.lut_start_in = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, 128'(done_cnt), 128'd1);
    chk({tag, "_write_count"}, 128'(write_cnt), 128'd16);
    chk({tag, "_queue_drained"}, 128'(exp_q.size()), 128'd0);
    chk({tag, "_idle_after"}, 128'(bus.lut_busy), 128'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, 128'(bus.WE), 128'd0);
    chk({tag, "_busy"}, 128'(bus.lut_busy), 128'd0);
    chk({tag, "_done"}, 128'(bus.lut_done), 128'd0);
    chk({tag, "_raddr"}, 128'(bus.ReadAddress), 128'd64);
    chk({tag, "_waddr"}, 128'(bus.WriteAddress), 128'd128);
    chk({tag, "_wbus"}, bus.WriteBus, 128'd0);
  endtask

  initial begin
    int cyc;
    checks = 0;
    passes = 0;
    write_cnt = 0;
    done_cnt = 0;
    bus.lut_start_in = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    clear_hist();
    for (int i = 0; i < 256; i++) hist[i] = 1;
    run("ramp", 1'b0);

    clear_hist();
    hist[10] = 100;
    hist[200] = 300;
    run("two_bins", 1'b0);

    clear_hist();
    hist[0] = 1; hist[1] = 1; hist[2] = 1;
    run("den2", 1'b0);

    clear_hist();
    hist[100] = 8294400;
    run("single_bin", 1'b0);

    clear_hist();
    hist[0] = 1;
    hist[255] = 8294399;
    run("extreme", 1'b0);

    clear_hist();
    for (int i = 0; i < 256; i++)
      hist[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 32000);
    run("random_dense", 1'b0);

    clear_hist();
    hist[$urandom_range(0, 255)] = $urandom_range(1, 8294400);
    run("random_single", 1'b0);

    // Abort mid-run around bin 70, then restart with spurious starts while busy.
    clear_hist();
    for (int i = 0; i < 256; i++) hist[i] = 1;
    build_expected();
    write_cnt = 0;
    @(negedge clk) bus.lut_start_in = 1'b1;
    @(negedge clk) bus.lut_start_in = 1'b0;
    cyc = 0;
    while (write_cnt < 4 && cyc < 9500) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_word4", 128'(write_cnt), 128'd4);
    repeat (215) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    chk("abort_we_held", 128'(bus.WE), 128'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    run("restart", 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
